// File: rtl/tone_sequencer.sv
// Square-wave tone engine: manual keypad or a small programmable note table
// with beat timing, an articulation gap and octave selection.
module tone_sequencer #(
    parameter int NUM_KEYS   = 7,
    parameter int DIV_W      = 20,
    parameter int BEAT_TICKS = 2_500_000,
    parameter int GAP_TICKS  = 250_000,
    parameter int SEQ_DEPTH  = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_KEYS-1:0]          Key,
    input  logic [1:0]                   Octave,
    input  logic                         AutoEn,
    input  logic                         SeqWrEn,
    input  logic [$clog2(SEQ_DEPTH)-1:0] SeqWrAddr,
    input  logic [5:0]                   SeqWrData,
    output logic                         Beep,
    output logic [3:0]                   NoteIdx,
    output logic [$clog2(SEQ_DEPTH)-1:0] SeqPos,
    output logic                         Playing
);
    localparam int ADDR_W = $clog2(SEQ_DEPTH);
    localparam int TICK_W = $clog2(8 * BEAT_TICKS);
    localparam logic [TICK_W-1:0] GAP_LOAD = TICK_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] seq_pos_q, seq_pos_d;
    logic [ADDR_W-1:0] pos_nxt;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        cur_note_q, cur_note_d;
    logic [3:0]        note_idx_q, note_idx_d;
    logic [1:0]        oct_q, oct_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  half_p;
    logic              beep_q, beep_d;
    logic              playing_q, playing_d;
    logic [5:0]        ent_0, ent_nxt;
    logic [5:0]        tbl_q [SEQ_DEPTH];

    function automatic logic [TICK_W-1:0] beat_load(input logic [2:0] dur);
        return TICK_W'(dur) * TICK_W'(BEAT_TICKS) - TICK_W'(1);
    endfunction

    // Lowest set key wins; note numbers are 1-based.
    function automatic logic [3:0] key_note(input logic [NUM_KEYS-1:0] keys);
        logic [3:0] n;
        n = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) n = 4'(i + 1);
        end
        return n;
    endfunction

    function automatic logic [3:0] seq_note(input logic [2:0] n);
        return (int'(n) <= NUM_KEYS) ? {1'b0, n} : 4'd0;
    endfunction

    function automatic logic [DIV_W-1:0] half_period(input logic [3:0] note, input logic [1:0] oct);
        logic [DIV_W-1:0] mid;
        case (note)
            4'd1:    mid = DIV_W'(16'h2553);
            4'd2:    mid = DIV_W'(16'h2141);
            4'd3:    mid = DIV_W'(16'h1DA0);
            4'd4:    mid = DIV_W'(16'h1BF6);
            4'd5:    mid = DIV_W'(16'h18E9);
            4'd6:    mid = DIV_W'(16'h1631);
            4'd7:    mid = DIV_W'(16'h13C5);
            4'd8:    mid = DIV_W'(16'h12A9);
            default: mid = '0;
        endcase
        case (oct)
            2'd0:    return mid << 1;
            2'd2:    return mid >> 1;
            default: return mid;
        endcase
    endfunction

    assign pos_nxt = seq_pos_q + ADDR_W'(1);
    assign ent_0   = tbl_q[0];
    assign ent_nxt = tbl_q[pos_nxt];

    always_comb begin
        state_d    = state_q;
        seq_pos_d  = seq_pos_q;
        tick_d     = tick_q;
        cur_note_d = cur_note_q;
        if (!AutoEn) begin
            state_d    = IDLE;
            seq_pos_d  = '0;
            tick_d     = '0;
            cur_note_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ent_0[2:0] != 3'd0) begin
                        state_d    = NOTE;
                        seq_pos_d  = '0;
                        cur_note_d = ent_0[5:3];
                        tick_d     = beat_load(ent_0[2:0]);
                    end
                end
                NOTE: begin
                    if (tick_q == '0) begin
                        state_d = GAP;
                        tick_d  = GAP_LOAD;
                    end else begin
                        tick_d = tick_q - TICK_W'(1);
                    end
                end
                GAP: begin
                    if (tick_q != '0) begin
                        tick_d = tick_q - TICK_W'(1);
                    end else if (ent_nxt[2:0] != 3'd0) begin
                        state_d    = NOTE;
                        seq_pos_d  = pos_nxt;
                        cur_note_d = ent_nxt[5:3];
                        tick_d     = beat_load(ent_nxt[2:0]);
                    end else if (ent_0[2:0] != 3'd0) begin
                        // End marker reached: loop back to entry 0 in the same cycle.
                        state_d    = NOTE;
                        seq_pos_d  = '0;
                        cur_note_d = ent_0[5:3];
                        tick_d     = beat_load(ent_0[2:0]);
                    end else begin
                        state_d   = IDLE;
                        seq_pos_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        note_idx_d = '0;
        if (Octave != 2'd3) begin
            if (!AutoEn && state_q == IDLE) begin
                note_idx_d = key_note(Key);
            end else if (AutoEn && state_d == NOTE) begin
                note_idx_d = seq_note(cur_note_d);
            end
        end
        playing_d = (state_d != IDLE);
        oct_d     = Octave;
    end

    assign half_p = half_period(note_idx_q, oct_q);

    // Any change of pitch restarts the divider with the output low.
    always_comb begin
        div_d  = div_q + DIV_W'(1);
        beep_d = beep_q;
        if (note_idx_d != note_idx_q || oct_d != oct_q || note_idx_q == '0) begin
            div_d  = '0;
            beep_d = 1'b0;
        end else if (div_q == half_p - DIV_W'(1)) begin
            div_d  = '0;
            beep_d = ~beep_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            seq_pos_q  <= '0;
            tick_q     <= '0;
            cur_note_q <= '0;
            note_idx_q <= '0;
            oct_q      <= '0;
            div_q      <= '0;
            beep_q     <= 1'b0;
            playing_q  <= 1'b0;
            for (int i = 0; i < SEQ_DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            seq_pos_q  <= seq_pos_d;
            tick_q     <= tick_d;
            cur_note_q <= cur_note_d;
            note_idx_q <= note_idx_d;
            oct_q      <= oct_d;
            div_q      <= div_d;
            beep_q     <= beep_d;
            playing_q  <= playing_d;
            if (SeqWrEn) begin
                tbl_q[SeqWrAddr] <= SeqWrData;
            end
        end
    end

    assign Beep    = beep_q;
    assign NoteIdx = note_idx_q;
    assign SeqPos  = seq_pos_q;
    assign Playing = playing_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: key decode table, tone periods and
// sequencer timing with BEAT_TICKS=4, GAP_TICKS=2, SEQ_DEPTH=4.
module tb_tone_sequencer;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [6:0] Key = '0;
    logic [1:0] Octave = 2'd1;
    logic       AutoEn = 1'b0;
    logic       SeqWrEn = 1'b0;
    logic [1:0] SeqWrAddr = '0;
    logic [5:0] SeqWrData = '0;
    logic       Beep;
    logic [3:0] NoteIdx;
    logic [1:0] SeqPos;
    logic       Playing;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0] key;
        logic [1:0] oct;
        int         note;
    } kvec_t;

    typedef struct {
        int note;
        int len;
        int pos;
    } seg_t;

    always #5 CLK = ~CLK;

    tone_sequencer #(
        .NUM_KEYS  (7),
        .DIV_W     (20),
        .BEAT_TICKS(4),
        .GAP_TICKS (2),
        .SEQ_DEPTH (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Key      (Key),
        .Octave   (Octave),
        .AutoEn   (AutoEn),
        .SeqWrEn  (SeqWrEn),
        .SeqWrAddr(SeqWrAddr),
        .SeqWrData(SeqWrData),
        .Beep     (Beep),
        .NoteIdx  (NoteIdx),
        .SeqPos   (SeqPos),
        .Playing  (Playing)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input int note, input int dur);
        SeqWrEn   = 1'b1;
        SeqWrAddr = 2'(a);
        SeqWrData = {3'(note), 3'(dur)};
        tick();
        SeqWrEn   = 1'b0;
    endtask

    task automatic count_until(input logic lvl, input int limit, output int n);
        n = 0;
        while (Beep !== lvl && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_beep"}, int'(Beep), 0);
        check({name, "_note"}, int'(NoteIdx), 0);
        check({name, "_pos"}, int'(SeqPos), 0);
        check({name, "_play"}, int'(Playing), 0);
    endtask

    initial begin
        kvec_t kv[9];
        seg_t  sg[7];
        int    n;

        kv[0] = '{7'b0000001, 2'd1, 1};
        kv[1] = '{7'b0000010, 2'd1, 2};
        kv[2] = '{7'b0010100, 2'd1, 3};
        kv[3] = '{7'b1000000, 2'd1, 7};
        kv[4] = '{7'b1111111, 2'd0, 1};
        kv[5] = '{7'b1100000, 2'd2, 6};
        kv[6] = '{7'b0001000, 2'd3, 0};
        kv[7] = '{7'b0000000, 2'd1, 0};
        kv[8] = '{7'b0110000, 2'd1, 5};

        sg[0] = '{1, 8, 0};
        sg[1] = '{0, 2, 0};
        sg[2] = '{0, 4, 1};
        sg[3] = '{0, 2, 1};
        sg[4] = '{5, 4, 2};
        sg[5] = '{0, 2, 2};
        sg[6] = '{1, 1, 0};

        // Reset state
        tick();
        tick();
        check_idle("reset");
        RST = 1'b0;

        // Manual key decode table
        for (int i = 0; i < 9; i++) begin
            Key    = kv[i].key;
            Octave = kv[i].oct;
            tick();
            check($sformatf("key%0d_note", i), int'(NoteIdx), kv[i].note);
            check($sformatf("key%0d_beep", i), int'(Beep), 0);
        end
        Key    = '0;
        Octave = 2'd1;
        tick();

        // Note 1, mid octave: first toggle after 0x2553 cycles, key release silences
        Key = 7'b0000001;
        tick();
        check("t1_note", int'(NoteIdx), 1);
        check("t1_beep0", int'(Beep), 0);
        count_until(1'b1, 20000, n);
        check("t1_half_period", n, 32'h2553);
        Key = '0;
        tick();
        check("t1_release_beep", int'(Beep), 0);
        check("t1_release_note", int'(NoteIdx), 0);

        // Note 3 mid, then octave drop mid-note restarts at double half-period
        Key = 7'b0010100;
        tick();
        check("t2_note", int'(NoteIdx), 3);
        repeat (8000) tick();
        check("t2_beep_before", int'(Beep), 1);
        Octave = 2'd0;
        tick();
        check("t2_restart_beep", int'(Beep), 0);
        check("t2_restart_note", int'(NoteIdx), 3);
        count_until(1'b1, 40000, n);
        check("t2_low_rise", n, 32'h3B40);
        count_until(1'b0, 40000, n);
        check("t2_low_fall", n, 32'h3B40);
        Key    = '0;
        Octave = 2'd1;
        tick();

        // Sequence with rest and end marker, looping back to entry 0
        wr(0, 1, 2);
        wr(1, 0, 1);
        wr(2, 5, 1);
        AutoEn = 1'b1;
        for (int s = 0; s < 7; s++) begin
            for (int c = 0; c < sg[s].len; c++) begin
                tick();
                check($sformatf("t3_s%0d_c%0d_note", s, c), int'(NoteIdx), sg[s].note);
                check($sformatf("t3_s%0d_c%0d_pos", s, c), int'(SeqPos), sg[s].pos);
                check($sformatf("t3_s%0d_c%0d_play", s, c), int'(Playing), 1);
            end
        end

        // AutoEn drop mid-note, then manual keys work again
        AutoEn = 1'b0;
        tick();
        check_idle("t5_autooff");
        Key = 7'b0000100;
        tick();
        check("t5_key_note", int'(NoteIdx), 3);
        Key = '0;
        tick();

        // Reset mid-note clears everything, including the table
        AutoEn = 1'b1;
        tick();
        check("t5_replay", int'(Playing), 1);
        check("t5_replay_note", int'(NoteIdx), 1);
        tick();
        RST = 1'b1;
        tick();
        check_idle("t5_rst");
        RST = 1'b0;

        // Empty table: auto mode stays idle and ignores keys
        Key = 7'b0000001;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("t6_c%0d_play", c), int'(Playing), 0);
            check($sformatf("t6_c%0d_note", c), int'(NoteIdx), 0);
            check($sformatf("t6_c%0d_beep", c), int'(Beep), 0);
        end
        AutoEn = 1'b0;
        Key    = '0;
        tick();

        // Full table wraps; same-cycle write uses old data, earlier write is picked up
        wr(0, 1, 1);
        wr(1, 2, 1);
        wr(2, 3, 1);
        wr(3, 4, 1);
        AutoEn = 1'b1;
        tick();
        check("t4_e0_note", int'(NoteIdx), 1);
        check("t4_e0_pos", int'(SeqPos), 0);
        repeat (5) tick();
        SeqWrEn   = 1'b1;
        SeqWrAddr = 2'd1;
        SeqWrData = {3'd7, 3'd1};
        tick();
        SeqWrEn = 1'b0;
        check("t4_e1_old_note", int'(NoteIdx), 2);
        check("t4_e1_pos", int'(SeqPos), 1);
        repeat (12) tick();
        check("t4_e3_note", int'(NoteIdx), 4);
        check("t4_e3_pos", int'(SeqPos), 3);
        wr(0, 6, 1);
        repeat (5) tick();
        check("t4_wrap_note", int'(NoteIdx), 6);
        check("t4_wrap_pos", int'(SeqPos), 0);
        repeat (6) tick();
        check("t4_new_e1_note", int'(NoteIdx), 7);
        check("t4_new_e1_pos", int'(SeqPos), 1);
        AutoEn = 1'b0;
        tick();
        check_idle("t4_off");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
